// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: main/side road intersection phase sequencer.
// Runs green/yellow/all-red phases timed by an external one-second tick.
// Main green is extended until there is demand. A pedestrian walk phase
// runs alongside side green, and an emergency input forces all red.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   one_sec_tick      one-cycle pulse per second from the timer
//   side_req          side-road vehicle sensor (level)
//   ped_req           pedestrian button (pulse)
//   emerg             emergency preempt (level)
//   rst_count         timer clear, high for the first cycle of every phase
//   main_light        {red,yellow,green} for the main road
//   side_light        {red,yellow,green} for the side road
//   walk              pedestrian walk lamp
//   phase             current state encoding (debug)
//   ped_pending       pedestrian request latched and not yet served
module traffic_phase_ctrl #(
  parameter int unsigned GREEN_MAIN_SEC = 10,
  parameter int unsigned GREEN_SIDE_SEC = 5,
  parameter int unsigned YELLOW_SEC     = 2,
  parameter int unsigned ALL_RED_SEC    = 1,
  parameter int unsigned CNT_W          = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       one_sec_tick,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emerg,
  output logic       rst_count,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR_B  = 3'd5,
    EMERG  = 3'd6
  } state_t;

  localparam int unsigned EW = CNT_W + 1;

  // Durations held one bit wider than the counter so "elapsed >= D" is never constant.
  localparam logic [EW-1:0] GM_DUR = EW'(GREEN_MAIN_SEC);
  localparam logic [EW-1:0] GS_DUR = EW'(GREEN_SIDE_SEC);
  localparam logic [EW-1:0] Y_DUR  = EW'(YELLOW_SEC);
  localparam logic [EW-1:0] AR_DUR = EW'(ALL_RED_SEC);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] w_sec_cnt_nxt;
  logic             r_rst_count;
  logic             r_walk;
  logic             r_ped_pending;
  logic [2:0]       r_main_light;
  logic [2:0]       r_side_light;
  logic             w_walk_nxt;
  logic             w_ped_nxt;
  logic [2:0]       w_main_nxt;
  logic [2:0]       w_side_nxt;
  logic             w_state_chg;
  logic             w_side_entry;

  // A tick landing in the first cycle of a phase belongs to the previous phase.
  logic             w_tick;
  logic [EW-1:0]    w_elapsed;
  logic             w_exit_gm;
  logic             w_exit_gs;
  logic             w_exit_y;
  logic             w_exit_ar;

  assign w_tick    = one_sec_tick & ~r_rst_count;
  assign w_elapsed = {1'b0, r_sec_cnt} + EW'(1);
  assign w_exit_gm = w_tick & (w_elapsed >= GM_DUR);
  assign w_exit_gs = w_tick & (w_elapsed >= GS_DUR);
  assign w_exit_y  = w_tick & (w_elapsed >= Y_DUR);
  assign w_exit_ar = w_tick & (w_elapsed >= AR_DUR);

  // Next state, counter, pedestrian bookkeeping and lamp decode of the next state.
  always_comb begin
    w_next_state  = r_state;
    w_sec_cnt_nxt = r_sec_cnt;
    w_walk_nxt    = 1'b0;
    w_ped_nxt     = r_ped_pending | ped_req;
    w_main_nxt    = LAMP_R;
    w_side_nxt    = LAMP_R;

    case (r_state)
      MAIN_G: begin
        if (emerg) begin
          w_next_state = MAIN_Y;
        end else if (w_exit_gm && (side_req || r_ped_pending)) begin
          w_next_state = MAIN_Y;
        end
      end
      MAIN_Y: begin
        if (w_exit_y) begin
          w_next_state = emerg ? EMERG : CLR_A;
        end
      end
      CLR_A: begin
        if (emerg) begin
          w_next_state = EMERG;
        end else if (w_exit_ar) begin
          w_next_state = SIDE_G;
        end
      end
      SIDE_G: begin
        if (emerg || w_exit_gs) begin
          w_next_state = SIDE_Y;
        end
      end
      SIDE_Y: begin
        if (w_exit_y) begin
          w_next_state = emerg ? EMERG : CLR_B;
        end
      end
      CLR_B: begin
        if (emerg) begin
          w_next_state = EMERG;
        end else if (w_exit_ar) begin
          w_next_state = MAIN_G;
        end
      end
      EMERG: begin
        if (!emerg) begin
          w_next_state = CLR_B;
        end
      end
      default: w_next_state = CLR_B;
    endcase

    w_state_chg  = (w_next_state != r_state);
    w_side_entry = (w_next_state == SIDE_G) && (r_state != SIDE_G);

    // Per-phase second counter: clears on change, saturates at all-ones.
    if (w_state_chg) begin
      w_sec_cnt_nxt = '0;
    end else if (w_tick && (r_sec_cnt != {CNT_W{1'b1}})) begin
      w_sec_cnt_nxt = r_sec_cnt + CNT_W'(1);
    end

    // Serving the request on side-green entry consumes it, including a same-cycle press.
    if (w_side_entry) begin
      w_walk_nxt = r_ped_pending | ped_req;
      w_ped_nxt  = 1'b0;
    end else if (w_next_state == SIDE_G) begin
      w_walk_nxt = r_walk;
    end

    case (w_next_state)
      MAIN_G:  w_main_nxt = LAMP_G;
      MAIN_Y:  w_main_nxt = LAMP_Y;
      SIDE_G:  w_side_nxt = LAMP_G;
      SIDE_Y:  w_side_nxt = LAMP_Y;
      default: begin
        w_main_nxt = LAMP_R;
        w_side_nxt = LAMP_R;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= CLR_B;
      r_sec_cnt     <= '0;
      r_rst_count   <= 1'b1;
      r_walk        <= 1'b0;
      r_ped_pending <= 1'b0;
      r_main_light  <= LAMP_R;
      r_side_light  <= LAMP_R;
    end else begin
      r_state       <= w_next_state;
      r_sec_cnt     <= w_sec_cnt_nxt;
      r_rst_count   <= w_state_chg;
      r_walk        <= w_walk_nxt;
      r_ped_pending <= w_ped_nxt;
      r_main_light  <= w_main_nxt;
      r_side_light  <= w_side_nxt;
    end
  end

  assign rst_count   = r_rst_count;
  assign main_light  = r_main_light;
  assign side_light  = r_side_light;
  assign walk        = r_walk;
  assign phase       = r_state;
  assign ped_pending = r_ped_pending;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios with literal
// expectations plus a randomized run against a rules-level phase model.
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       reset_n;
  logic       one_sec_tick;
  logic       side_req;
  logic       ped_req;
  logic       emerg;
  logic       rst_count;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;
  logic       ped_pending;

  traffic_phase_ctrl #(
    .GREEN_MAIN_SEC(3),
    .GREEN_SIDE_SEC(2),
    .YELLOW_SEC    (1),
    .ALL_RED_SEC   (1),
    .CNT_W         (6)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .one_sec_tick(one_sec_tick),
    .side_req    (side_req),
    .ped_req     (ped_req),
    .emerg       (emerg),
    .rst_count   (rst_count),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk        (walk),
    .phase       (phase),
    .ped_pending (ped_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int tick_ctr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 MAIN_G, 1 MAIN_Y, 2 CLR_A, 3 SIDE_G, 4 SIDE_Y, 5 CLR_B, 6 EMERG.
  int dur  [7] = '{3, 1, 1, 2, 1, 1, 0};
  int succ [7] = '{1, 2, 3, 4, 5, 0, 5};

  int m_phase = 5;
  int m_ticks = 0;
  bit m_rc    = 1'b1;
  bit m_pend  = 1'b0;
  bit m_walk  = 1'b0;
  int m_nxt;

  function automatic int next_phase(input int p, input int ticks, input bit rc,
                                    input bit tick, input bit side, input bit pend,
                                    input bit em);
    bit done;
    done = tick && !rc && (ticks + 1 >= dur[p]);
    if (p == 6) return em ? 6 : 5;
    if (em && (p == 0 || p == 3)) return succ[p];
    if (em && (p == 2 || p == 5)) return 6;
    if (!done) return p;
    if (p == 0 && !(side || pend)) return p;
    return em ? 6 : succ[p];
  endfunction

  function automatic int lamp_main(input int p);
    return (p == 0) ? 1 : (p == 1) ? 2 : 4;
  endfunction

  function automatic int lamp_side(input int p);
    return (p == 3) ? 1 : (p == 4) ? 2 : 4;
  endfunction

  always_comb m_nxt = next_phase(m_phase, m_ticks, m_rc, one_sec_tick, side_req, m_pend, emerg);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 5;
      m_ticks <= 0;
      m_rc    <= 1'b1;
      m_pend  <= 1'b0;
      m_walk  <= 1'b0;
    end else begin
      m_phase <= m_nxt;
      m_rc    <= (m_nxt != m_phase);
      m_ticks <= (m_nxt != m_phase) ? 0 :
                 (one_sec_tick && !m_rc) ? ((m_ticks < 63) ? m_ticks + 1 : 63) : m_ticks;
      if (m_nxt == 3 && m_phase != 3) begin
        m_walk <= m_pend || ped_req;
        m_pend <= 1'b0;
      end else begin
        m_walk <= (m_nxt == 3) ? m_walk : 1'b0;
        m_pend <= m_pend || ped_req;
      end
    end
  end

  // Continuous compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_phase",  int'(phase),       m_phase);
      chk("m_main",   int'(main_light),  lamp_main(m_phase));
      chk("m_side",   int'(side_light),  lamp_side(m_phase));
      chk("m_walk",   int'(walk),        int'(m_walk));
      chk("m_pend",   int'(ped_pending), int'(m_pend));
      chk("m_rstcnt", int'(rst_count),   int'(m_rc));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    tick_ctr++;
    one_sec_tick = (tick_ctr % 8 == 7);
  endtask

  task automatic wait_phase(input string name, input int p, input int budget);
    int n;
    n = 0;
    while (int'(phase) != p && n < budget) begin
      cyc();
      n++;
    end
    chk(name, int'(phase), p);
  endtask

  int exp_seq [6] = '{1, 2, 3, 4, 5, 0};
  int seq [$];

  initial begin
    int n;
    int ticks;
    int pulses;
    int ticks_g;
    int ticks_s;

    reset_n      = 1'b1;
    one_sec_tick = 1'b0;
    side_req     = 1'b0;
    ped_req      = 1'b0;
    emerg        = 1'b0;
    #1 reset_n   = 1'b0;
    chk_en       = 1'b1;
    repeat (3) cyc();
    reset_n = 1'b1;

    // 1: reset release, idle main green holds well past counter saturation
    chk("rel_rstcnt", int'(rst_count), 1);
    chk("rel_phase",  int'(phase), 5);
    chk("rel_main",   int'(main_light), 4);
    chk("rel_side",   int'(side_light), 4);
    wait_phase("t1_reach_mg", 0, 40);
    chk("t1_main", int'(main_light), 1);
    chk("t1_side", int'(side_light), 4);
    ticks = 0;
    n = 0;
    while (ticks < 65 && n < 1000) begin
      cyc();
      n++;
      if (one_sec_tick && !rst_count && phase == 3'd0) ticks++;
    end
    cyc();
    chk("t1_hold_mg", int'(phase), 0);

    // 2: demand after saturated minimum green exits on the very next tick
    side_req = 1'b1;
    ticks = 0;
    n = 0;
    while (phase == 3'd0 && n < 100) begin
      cyc();
      n++;
      if (phase == 3'd0 && one_sec_tick && !rst_count) ticks++;
    end
    chk("t2_late_exit_ticks", ticks, 1);
    chk("t2_reach_my", int'(phase), 1);
    wait_phase("t2_reach_mg", 0, 200);
    pulses = 0; ticks_g = 0; ticks_s = 0; n = 0;
    seq.delete();
    do begin
      cyc();
      n++;
      if (rst_count) begin
        pulses++;
        seq.push_back(int'(phase));
      end else if (one_sec_tick) begin
        if (phase == 3'd0) ticks_g++;
        if (phase == 3'd3) ticks_s++;
      end
    end while (!(phase == 3'd0 && rst_count) && n < 400);
    chk("t2_pulses", pulses, 6);
    chk("t2_ticks_mg", ticks_g, 3);
    chk("t2_ticks_sg", ticks_s, 2);
    for (int i = 0; i < 6; i++) begin
      chk("t2_seq", (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
    end

    // 3: pedestrian request alone drives a side cycle with walk
    side_req = 1'b0;
    ped_req  = 1'b1;
    cyc();
    ped_req  = 1'b0;
    chk("t3_pend", int'(ped_pending), 1);
    wait_phase("t3_reach_sg", 3, 200);
    chk("t3_walk", int'(walk), 1);
    chk("t3_pend_clr", int'(ped_pending), 0);
    chk("t3_side", int'(side_light), 1);
    wait_phase("t3_reach_sy", 4, 100);
    chk("t3_walk_off", int'(walk), 0);

    // 4: press in the CLR_A->SIDE_G transition cycle is served directly
    side_req = 1'b1;
    wait_phase("t4_reach_ca", 2, 300);
    side_req = 1'b0;
    n = 0;
    while (!(phase == 3'd2 && one_sec_tick && !rst_count) && n < 50) begin
      cyc();
      n++;
    end
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    chk("t4_phase", int'(phase), 3);
    chk("t4_walk", int'(walk), 1);
    chk("t4_pend", int'(ped_pending), 0);

    // 5: emergency during side green with walk on
    repeat (2) cyc();
    chk("t5_pre_walk", int'(walk), 1);
    emerg = 1'b1;
    cyc();
    chk("t5_phase_sy", int'(phase), 4);
    chk("t5_walk", int'(walk), 0);
    chk("t5_side", int'(side_light), 2);
    wait_phase("t5_reach_em", 6, 50);
    chk("t5_main_r", int'(main_light), 4);
    chk("t5_side_r", int'(side_light), 4);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    repeat (10) cyc();
    chk("t5_hold_em", int'(phase), 6);
    chk("t5_pend_em", int'(ped_pending), 1);
    emerg = 1'b0;
    cyc();
    chk("t5_phase_cb", int'(phase), 5);
    chk("t5_pend_cb", int'(ped_pending), 1);
    wait_phase("t5_reach_mg", 0, 50);
    chk("t5_main_g", int'(main_light), 1);

    // 6: asynchronous reset in SIDE_Y takes effect between clock edges
    wait_phase("t6_reach_sy", 4, 300);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_phase", int'(phase), 5);
    chk("t6_main", int'(main_light), 4);
    chk("t6_side", int'(side_light), 4);
    chk("t6_walk", int'(walk), 0);
    chk("t6_rstcnt", int'(rst_count), 1);
    repeat (3) cyc();
    reset_n = 1'b1;
    chk("t6_rel_rstcnt", int'(rst_count), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      cyc();
      if ($urandom_range(0, 15) == 0) side_req = ~side_req;
      ped_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) emerg = ~emerg;
      if ($urandom_range(0, 1999) == 0) begin
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
      end
    end

    cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
